// File: rtl/mem_tg_mc_ctrl.sv
// rtl/mem_tg_mc_ctrl.sv - multi-channel MEM TG MMIO control/status with per-channel start FSMs
// Optional MEM_TG_PERF_CNT_EN builds per-channel CLOCKS counters; otherwise one shared timeout counter.
module mem_tg_mc_ctrl #(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 48,
    parameter logic [63:0] AFU_ID_L = 64'hA3DC5B831F5CECBB,
    parameter logic [63:0] AFU_ID_H = 64'h4DADEA342C7848CB,
    parameter logic [63:0] DFH_VAL  = 64'h1000010000001000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_wr,
    input  logic              csr_rd,
    input  logic [11:0]       csr_addr,
    input  logic [63:0]       csr_wdata,
    output logic [63:0]       csr_rdata,
    output logic              csr_rvalid,
    output logic [NUM_CH-1:0] tg_start,
    input  logic [NUM_CH-1:0] tg_done,
    input  logic [NUM_CH-1:0] tg_pass,
    input  logic [NUM_CH-1:0] tg_fail
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4,
        ST_TMO   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [8:0]        w_word;
    logic              w_wr_ctrl;
    logic              w_wr_scratch;
    logic              w_wr_timeout;
    logic [NUM_CH-1:0] w_start_req;
    logic [NUM_CH-1:0] w_clr_req;
    logic [NUM_CH-1:0] w_launch;
    logic [NUM_CH-1:0] w_active;
    logic [NUM_CH-1:0] w_tmo_hit;
    logic [31:0]       w_stat;
    logic [63:0]       w_rd_mux;
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [2:0]        w_unused_addr;

    state_t            r_state     [NUM_CH];
    state_t            w_state_nxt [NUM_CH];
    logic [63:0]       r_scratch;
    logic [CNT_W-1:0]  r_timeout;
    logic [63:0]       r_rdata;
    logic              r_rvalid;

    assign w_word        = csr_addr[11:3];
    assign w_unused_addr = csr_addr[2:0];
    assign w_wr_scratch  = csr_wr && (w_word == 9'd5);
    assign w_wr_ctrl     = csr_wr && (w_word == 9'd6);
    assign w_wr_timeout  = csr_wr && (w_word == 9'd8);

    always_comb begin
        w_start_req = '0;
        w_clr_req   = '0;
        w_tmo_hit   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_start_req[n] = w_wr_ctrl && csr_wdata[n];
            w_clr_req[n]   = w_wr_ctrl && csr_wdata[8+n];
            w_tmo_hit[n]   = (r_timeout != '0) && (w_cnt[n] == r_timeout);
        end
    end

    // Start beats clear when both land together; a start to a busy channel is dropped.
    always_comb begin
        w_launch = '0;
        w_active = '0;
        tg_start = '0;
        w_stat   = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_state_nxt[n] = r_state[n];
            case (r_state[n])
                ST_IDLE: begin
                    if (w_start_req[n]) begin
                        w_state_nxt[n] = ST_START;
                        w_launch[n]    = 1'b1;
                    end
                end
                ST_START: w_state_nxt[n] = ST_RUN;
                ST_RUN: begin
                    if (tg_done[n] && tg_fail[n]) begin
                        w_state_nxt[n] = ST_FAIL;
                    end else if (tg_done[n] && tg_pass[n]) begin
                        w_state_nxt[n] = ST_PASS;
                    end else if (w_tmo_hit[n]) begin
                        w_state_nxt[n] = ST_TMO;
                    end
                end
                default: begin
                    if (w_start_req[n]) begin
                        w_state_nxt[n] = ST_START;
                        w_launch[n]    = 1'b1;
                    end else if (w_clr_req[n]) begin
                        w_state_nxt[n] = ST_IDLE;
                    end
                end
            endcase
            w_active[n]      = (r_state[n] == ST_START) || (r_state[n] == ST_RUN);
            tg_start[n]      = (r_state[n] == ST_START);
            w_stat[4*n +: 4] = {r_state[n] == ST_TMO, r_state[n] == ST_FAIL,
                                r_state[n] == ST_PASS, w_active[n]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_state[n] <= ST_IDLE;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_state[n] <= w_state_nxt[n];
            end
        end
    end

`ifdef MEM_TG_PERF_CNT_EN
    logic [CNT_W-1:0] r_clocks [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CH; n++) begin
                r_clocks[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_launch[n]) begin
                    r_clocks[n] <= '0;
                end else if (w_active[n] && (r_clocks[n] != CNT_MAX)) begin
                    r_clocks[n] <= r_clocks[n] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_cnt[n] = r_clocks[n];
        end
    end
`else
    // One counter serves every channel, so timeouts are only exact for the most recent start.
    logic [CNT_W-1:0] r_shared_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shared_cnt <= '0;
        end else if (|w_launch) begin
            r_shared_cnt <= '0;
        end else if ((|w_active) && (r_shared_cnt != CNT_MAX)) begin
            r_shared_cnt <= r_shared_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            w_cnt[n] = r_shared_cnt;
        end
    end
`endif

    always_comb begin
        w_rd_mux = '0;
        case (w_word)
            9'd0:    w_rd_mux = DFH_VAL;
            9'd1:    w_rd_mux = AFU_ID_L;
            9'd2:    w_rd_mux = AFU_ID_H;
            9'd5:    w_rd_mux = r_scratch;
            9'd7:    w_rd_mux = 64'(w_stat);
            9'd8:    w_rd_mux = 64'(r_timeout);
            default: w_rd_mux = '0;
        endcase
`ifdef MEM_TG_PERF_CNT_EN
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_word == 9'(10 + n)) begin
                w_rd_mux = 64'(r_clocks[n]);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= '0;
            r_timeout <= CNT_MAX;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            if (w_wr_scratch) begin
                r_scratch <= csr_wdata;
            end
            if (w_wr_timeout) begin
                r_timeout <= csr_wdata[CNT_W-1:0];
            end
            r_rvalid <= csr_rd;
            r_rdata  <= csr_rd ? w_rd_mux : '0;
        end
    end

    assign csr_rdata  = r_rdata;
    assign csr_rvalid = r_rvalid;

endmodule

// File: doc/mem_tg_mc_ctrl.md
# mem_tg_mc_ctrl

Multi-channel control and status block for the memory traffic-generator AFU, generalising the single-channel MEM TG control/status registers to NUM_CH independent EMIF channels. It decodes the AFU's 64-bit MMIO register window: DFH, AFU ID, scratch, per-channel start control, packed status, a shared timeout limit and per-channel clock counters. It runs one small state machine per channel, which issues a start pulse to the channel's traffic generator and tracks it to completion, failure or timeout. It sits between the PF/VF MMIO bridge and the per-channel TG cores.

## Interface
- NUM_CH, 4: channel count, 1..8.
- CNT_W, 48: width of the per-channel clock counters and of the timeout limit.
- AFU_ID_L, 64'hA3DC5B831F5CECBB: value returned at 0x08.
- AFU_ID_H, 64'h4DADEA342C7848CB: value returned at 0x10.
- DFH_VAL, 64'h1000010000001000: value returned at 0x00.

Ports (clock and reset first):
- clk  in  1  block clock.
- rst_n  in  1  asynchronous, active-low reset.
- csr_wr  in  1  write strobe, one cycle.
- csr_rd  in  1  read strobe, one cycle.
- csr_addr  in  12  byte address; bits [2:0] are ignored.
- csr_wdata  in  64  write data.
- csr_rdata  out  64  read data.
- csr_rvalid  out  1  read data valid.
- tg_start  out  NUM_CH  one-cycle start pulse, one bit per channel.
- tg_done  in  NUM_CH  level; TG test complete.
- tg_pass  in  NUM_CH  qualified by tg_done.
- tg_fail  in  NUM_CH  qualified by tg_done.

## Operation
Register map (64-bit registers, 8-byte aligned):
- 0x00 DFH: read-only.
- 0x08 / 0x10 ID_L / ID_H: read-only.
- 0x18 NEXT: reads 0.
- 0x20 RSVD: reads 0.
- 0x28 SCRATCH: read/write. Reset value 0.
- 0x30 CTRL:
  - Write bits [NUM_CH-1:0] = start mask.
  - Write bits [NUM_CH+7:8] = per-channel clear mask.
  - Reads 0.
- 0x38 STAT: read-only. Nibble n (bits [4n+3:4n]) = {timeout, fail, pass, active} for channel n. Unused nibbles read 0.
- 0x40 TIMEOUT: read/write, lower CNT_W bits. Reset value all-ones. Value 0 disables the timeout.
- 0x50 + 8n CLOCKS[n]: read-only, CNT_W bits, zero-extended to 64.
- Any other address: reads 0; writes are dropped.

Per-channel FSM states: IDLE, START, RUN, PASS, FAIL, TMO.
- IDLE → START: on a CTRL write with start bit n set. This also clears CLOCKS[n].
- START: drives tg_start[n] for exactly one cycle, then → RUN.
- RUN → PASS: on tg_done & tg_pass & ~tg_fail.
- RUN → FAIL: on tg_done & tg_fail. Fail wins if both tg_pass and tg_fail are high.
- RUN → TMO: when CLOCKS[n] == TIMEOUT and TIMEOUT != 0.
- PASS / FAIL / TMO: hold until a clear bit or a new start bit for channel n. Clear → IDLE. Start → START.
- A start bit for a channel in START or RUN is ignored.
- If start and clear are both set for the same channel, start wins.
- Status bits:
  - active = state is START or RUN.
  - pass, fail and timeout are one-hot with their states.
- CLOCKS[n] increments every cycle in START or RUN, saturates at all-ones, and holds in every other state.

## Timing
- Reads: csr_rvalid and csr_rdata are registered one cycle after csr_rd. csr_rdata is 0 whenever csr_rvalid is low.
- csr_rd and csr_wr asserted in the same cycle: both are performed. The read returns the pre-write value.
- A CTRL write in cycle T puts the channel in START in T+1 and pulses tg_start in T+1.
- tg_done is sampled from T+2 onward, i.e. from the first RUN cycle.
- A STAT read issued in the same cycle as a state change returns the pre-change value.
- Reset values: csr_rdata = 0, csr_rvalid = 0, tg_start = 0, all FSMs in IDLE, CLOCKS = 0, SCRATCH = 0, TIMEOUT = all-ones.
- Reset asserted mid-test forces IDLE immediately. tg_start drops asynchronously.

## Configuration
- MEM_TG_PERF_CNT_EN defined: CLOCKS[n] registers are implemented as described above.
- MEM_TG_PERF_CNT_EN undefined:
  - No CLOCKS counters are built, and 0x50+ reads return 0.
  - The timeout uses a single shared free-running CNT_W counter per active channel group, cleared on any start.
  - The timeout is therefore approximate when channels are started at different times.

## Test plan
- Reset, then read 0x00, 0x08, 0x10 and 0x28 → DFH_VAL, AFU_ID_L, AFU_ID_H and 0, each with csr_rvalid exactly one cycle after csr_rd.
- Write 0x30 = 0x5 with NUM_CH=4 → tg_start = 4'b0101 for one cycle, STAT = 0x0101. Assert tg_done[0] & tg_pass[0] after 100 cycles → STAT nibble 0 = 0x2, and CLOCKS[0] = 101 (counted over START plus 100 RUN cycles).
- Channel 2 running: assert tg_done & tg_pass & tg_fail on channel 2 together → nibble 2 = 0x4 (FAIL). A start issued to channel 2 while it is still in RUN produces no tg_start pulse.
- Write TIMEOUT = 50, start channel 1, never assert done → nibble 1 = 0x8 when CLOCKS[1] reaches 50. Then write 0x30 = 0x200 → nibble 1 = 0x0.
- Pulse rst_n low while channel 3 is in RUN → STAT = 0, TIMEOUT = all-ones, tg_start = 0. Channel 3 restarts cleanly on the next CTRL write.
- Read 0x48 and 0x7F8, and write 0x7F8 → reads return 0; other register contents are unchanged.
